// File: rtl/mix_char_out_pkg.sv
// Shared types and constants for the MIX character-output controller: unit defaults,
// end-of-line codes, command-queue entry and the MIX-to-ASCII translation table.
package mix_out_pkg;

  localparam int unsigned DefCardUnit      = 17;
  localparam int unsigned DefPrinterUnit   = 18;
  localparam int unsigned DefTerminalUnit  = 19;
  localparam int unsigned DefCardWords     = 16;
  localparam int unsigned DefPrinterWords  = 24;
  localparam int unsigned DefTerminalWords = 14;

  localparam logic [6:0] AsciiCr = 7'd13;
  localparam logic [6:0] AsciiLf = 7'd10;

  localparam int unsigned QAddrW = 12;

  typedef struct packed {
    logic [5:0]        unit;
    logic [QAddrW-1:0] addr;
  } q_entry_t;

  typedef enum logic [1:0] {StIdle, StReq, StChar, StEol} state_e;

  function automatic logic [6:0] mix_to_ascii(logic [5:0] c);
    logic [6:0] a;
    a = 7'h3f;
    if (c == 6'd0) a = 7'h20;
    else if (c <= 6'd9) a = 7'd64 + 7'(c);
    else if (c >= 6'd11 && c <= 6'd19) a = 7'd63 + 7'(c);
    else if (c >= 6'd22 && c <= 6'd29) a = 7'd61 + 7'(c);
    else if (c >= 6'd30 && c <= 6'd39) a = 7'd18 + 7'(c);
    else begin
      case (c)
        6'd40: a = 7'h2e;
        6'd41: a = 7'h2c;
        6'd42: a = 7'h28;
        6'd43: a = 7'h29;
        6'd44: a = 7'h2b;
        6'd45: a = 7'h2d;
        6'd46: a = 7'h2a;
        6'd47: a = 7'h2f;
        6'd48: a = 7'h3d;
        6'd49: a = 7'h24;
        6'd50: a = 7'h3c;
        6'd51: a = 7'h3e;
        6'd52: a = 7'h40;
        6'd53: a = 7'h3b;
        6'd54: a = 7'h3a;
        6'd55: a = 7'h27;
        default: a = 7'h3f;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/mix_char_out_if.sv
// CPU/memory-side bus of the MIX character-output controller.
interface mix_char_out_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WORD_W = 30,
  parameter int unsigned QDEPTH = 2
);
  logic                           start;
  logic [5:0]                     field;
  logic [ADDR_W-1:0]              addressin;
  logic                           stop;
  logic                           busy;
  logic [$clog2(QDEPTH+1)-1:0]    pending;
  logic                           bad_unit;
  logic [ADDR_W-1:0]              addressout;
  logic                           request;
  logic                           load;
  logic [WORD_W-1:0]              in;
  logic                           tx;

  modport master (
    output start, field, addressin, load, in,
    input  stop, busy, pending, bad_unit, addressout, request, tx
  );

  modport slave (
    input  start, field, addressin, load, in,
    output stop, busy, pending, bad_unit, addressout, request, tx
  );
endinterface

// File: rtl/mix_char_out_uart_tx.sv
// 7-bit UART transmitter: start bit, 7 data bits LSB first, one stop bit.
module UartTX #(
  parameter int unsigned ClksPerBit = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] in,
  output logic       ready,
  output logic       tx
);
  localparam int unsigned DivW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  logic [8:0]      sh_q;
  logic [3:0]      bits_q;
  logic [DivW-1:0] div_q;

  assign ready = (bits_q == 4'd0);
  assign tx    = sh_q[0];

  // Ones shift in behind the frame so the line idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '1;
      bits_q <= 4'd0;
      div_q  <= '0;
    end else if (load && ready) begin
      sh_q   <= {1'b1, in, 1'b0};
      bits_q <= 4'd9;
      div_q  <= '0;
    end else if (bits_q != 4'd0) begin
      if (div_q == DivW'(ClksPerBit - 1)) begin
        div_q  <= '0;
        sh_q   <= {1'b1, sh_q[8:1]};
        bits_q <= bits_q - 4'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mix_char_out.sv
// MIX character-output controller: queued OUT commands, word fetch, MIX->ASCII, UART.
// Define MIX_OUT_CRLF_EN to end each block with CR LF instead of LF alone.
module mix_char_out
  import mix_out_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned BYTE_W         = 6,
  parameter int unsigned WORD_BYTES     = 5,
  parameter int unsigned QDEPTH         = 2,
  parameter int unsigned CARD_UNIT      = DefCardUnit,
  parameter int unsigned PRINTER_UNIT   = DefPrinterUnit,
  parameter int unsigned TERMINAL_UNIT  = DefTerminalUnit,
  parameter int unsigned CARD_WORDS     = DefCardWords,
  parameter int unsigned PRINTER_WORDS  = DefPrinterWords,
  parameter int unsigned TERMINAL_WORDS = DefTerminalWords,
  parameter int unsigned CLKS_PER_BIT   = 4
) (
  input logic           clk,
  input logic           reset,
  mix_char_out_if.slave bus
);
  localparam int unsigned WordW = WORD_BYTES * BYTE_W;
  localparam int unsigned CntW  = $clog2(QDEPTH + 1);
  localparam int unsigned PtrW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned BIdxW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  state_e            state_q, state_d;
  logic [5:0]        unit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wc_q;
  logic [WordW-1:0]  word_q;
  logic [BIdxW-1:0]  bidx_q;
  logic              eol_idx_q;
  q_entry_t          q_mem [QDEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              stall_q;
  q_entry_t          stall_entry_q;
  logic              stop_q, bad_q;

  logic              unit_ok, word_last, last_byte, eol_last, char_fire, blk_done;
  logic              cmd, activate, push_cmd, stall_set, stall_release, push, pop, q_full;
  logic              uart_ready, uart_load;
  logic [6:0]        uart_char, eol_char;
  logic [BYTE_W-1:0] cur_byte;
  q_entry_t          new_entry, push_entry, head;

  function automatic logic [7:0] block_words(logic [5:0] u);
    if (u == 6'(CARD_UNIT)) return 8'(CARD_WORDS);
    if (u == 6'(PRINTER_UNIT)) return 8'(PRINTER_WORDS);
    return 8'(TERMINAL_WORDS);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MIX_OUT_CRLF_EN
  assign eol_last = (eol_idx_q == 1'b1);
  assign eol_char = eol_idx_q ? AsciiLf : AsciiCr;
`else
  assign eol_last = (eol_idx_q == 1'b0);
  assign eol_char = AsciiLf;
`endif

  assign unit_ok   = (bus.field == 6'(CARD_UNIT)) || (bus.field == 6'(PRINTER_UNIT)) ||
                     (bus.field == 6'(TERMINAL_UNIT));
  assign word_last = (wc_q == block_words(unit_q) - 8'd1);
  assign last_byte = (bidx_q == BIdxW'(WORD_BYTES - 1));
  assign cur_byte  = word_q[(WORD_BYTES - 1 - int'(bidx_q)) * BYTE_W +: BYTE_W];
  assign char_fire = ((state_q == StChar) || (state_q == StEol)) && uart_ready;
  assign blk_done  = (state_q == StEol) && uart_ready && eol_last;
  assign q_full    = (cnt_q == CntW'(QDEPTH));
  assign head      = q_mem[rd_ptr_q];

  // A pop at block end frees a slot for a push arriving in the same cycle.
  assign pop           = blk_done && (cnt_q != '0);
  assign cmd           = bus.start && !stall_q;
  assign activate      = cmd && unit_ok && ((state_q == StIdle) || (blk_done && cnt_q == '0));
  assign push_cmd      = cmd && unit_ok && !activate && (!q_full || pop);
  assign stall_set     = cmd && unit_ok && !activate && q_full && !pop;
  assign stall_release = stall_q && pop;
  assign push          = push_cmd || stall_release;

  always_comb begin
    new_entry.unit = bus.field;
    new_entry.addr = QAddrW'(bus.addressin);
    push_entry     = stall_release ? stall_entry_q : new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (activate) state_d = StReq;
      StReq:   if (bus.load) state_d = StChar;
      StChar:  if (char_fire && last_byte) state_d = word_last ? StEol : StReq;
      StEol:   if (blk_done) state_d = (pop || activate) ? StReq : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.request = (state_q == StReq);
    bus.busy    = (state_q != StIdle);
    uart_load   = 1'b0;
    uart_char   = mix_to_ascii(6'(cur_byte));
    unique case (state_q)
      StChar:  uart_load = uart_ready;
      StEol: begin
        uart_load = uart_ready;
        uart_char = eol_char;
      end
      default: ;
    endcase
  end

  assign bus.stop       = stop_q;
  assign bus.bad_unit   = bad_q;
  assign bus.pending    = cnt_q;
  assign bus.addressout = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_q    <= '0;
      addr_q    <= '0;
      wc_q      <= '0;
      word_q    <= '0;
      bidx_q    <= '0;
      eol_idx_q <= 1'b0;
    end else begin
      if (state_q == StReq && bus.load) begin
        word_q <= bus.in;
        bidx_q <= '0;
      end
      if (state_q == StChar && char_fire) begin
        if (last_byte) begin
          bidx_q <= '0;
          if (!word_last) begin
            addr_q <= addr_q + 1'b1;
            wc_q   <= wc_q + 8'd1;
          end
        end else begin
          bidx_q <= bidx_q + 1'b1;
        end
      end
      if (state_q == StEol && char_fire) eol_idx_q <= eol_last ? 1'b0 : eol_idx_q + 1'b1;
      if (activate) begin
        unit_q <= bus.field;
        addr_q <= bus.addressin;
        wc_q   <= '0;
      end else if (pop) begin
        unit_q <= head.unit;
        addr_q <= ADDR_W'(head.addr);
        wc_q   <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(QDEPTH); i++) q_mem[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      stall_q       <= 1'b0;
      stall_entry_q <= '0;
      stop_q        <= 1'b0;
      bad_q         <= 1'b0;
    end else begin
      if (push) begin
        q_mem[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (stall_set) begin
        stall_q       <= 1'b1;
        stall_entry_q <= new_entry;
      end else if (stall_release) begin
        stall_q <= 1'b0;
      end
      stop_q <= (cmd && (!unit_ok || activate || push_cmd)) || stall_release;
      bad_q  <= cmd && !unit_ok;
    end
  end

  UartTX #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .reset(reset),
    .load (uart_load),
    .in   (uart_char),
    .ready(uart_ready),
    .tx   (bus.tx)
  );
endmodule

// File: tb/tb_mix_char_out.sv
// Bench for mix_char_out: memory responder, UART receiver and a block-level model.
module tb_mix_char_out;
  localparam int P = 4;
`ifdef MIX_OUT_CRLF_EN
  localparam int EolLen = 2;
`else
  localparam int EolLen = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mix_char_out_if #(.ADDR_W(12), .WORD_W(30), .QDEPTH(2)) bus ();

  mix_char_out #(.ADDR_W(12), .QDEPTH(2), .CLKS_PER_BIT(P)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad = 0;
  logic [29:0] mem [4096];
  string tbl;
  int exp_addr[$];
  int exp_chr[$];
  int req_log[$];
  int rx_log[$];
  int rx_cnt = 0;
  logic [6:0] rx_sh;
  logic stop_prev = 1'b0;
  logic bad_prev = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Model: a block is its addresses in order, then each byte's character, then end-of-line.
  task automatic add_block(input int unit, input int base);
    int n;
    n = (unit == 17) ? 16 : (unit == 18) ? 24 : 14;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % 4096;
      exp_addr.push_back(a);
      for (int b = 0; b < 5; b++) begin
        int code;
        code = int'((mem[a] >> (6 * (4 - b))) & 30'h3f);
        exp_chr.push_back(int'(tbl[code]));
      end
    end
    if (EolLen == 2) exp_chr.push_back(13);
    exp_chr.push_back(10);
  endtask

  task automatic issue(input int f, input int m, input bit add);
    bus.start = 1'b1;
    bus.field = 6'(f);
    bus.addressin = 12'(m);
    if (add) add_block(f, m);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while ((bus.busy || exp_addr.size() != 0 || exp_chr.size() != 0 || rx_cnt != 0) &&
           n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", int'(n < limit), 1);
  endtask

  // Compare process: serves memory reads, decodes tx, checks both against the model.
  always @(negedge clk) begin
    if (reset) begin
      bus.load = 1'b0;
      rx_cnt = 0;
      stop_prev = 1'b0;
      bad_prev = 1'b0;
    end else begin
      if (bus.load) begin
        bus.load = 1'b0;
      end else if (bus.request) begin
        if (exp_addr.size() == 0) chk("spurious_request", int'(bus.addressout), -1);
        else chk("req_addr", int'(bus.addressout), exp_addr.pop_front());
        req_log.push_back(int'(bus.addressout));
        bus.in = mem[bus.addressout];
        bus.load = 1'b1;
      end
      if (stop_prev) chk("stop_width", int'(bus.stop), 0);
      if (bad_prev) chk("bad_width", int'(bus.bad_unit), 0);
      stop_prev = bus.stop;
      bad_prev = bus.bad_unit;
      if (rx_cnt == 0) begin
        if (bus.tx == 1'b0) rx_cnt = 1;
      end else begin
        if (rx_cnt % P == P / 2 && rx_cnt / P >= 1 && rx_cnt / P <= 7)
          rx_sh[rx_cnt / P - 1] = bus.tx;
        if (rx_cnt == 8 * P + P / 2) begin
          chk("stop_bit", int'(bus.tx), 1);
          rx_log.push_back(int'(rx_sh));
          if (exp_chr.size() == 0) chk("spurious_char", int'(rx_sh), -1);
          else chk("char", int'(rx_sh), exp_chr.pop_front());
          rx_cnt = 0;
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  initial begin
    int n_a;
    int found;
    bus.start = 1'b0;
    bus.field = '0;
    bus.addressin = '0;
    tbl = " ABCDEFGHI?JKLMNOPQR??STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";
    for (int a = 0; a < 4096; a++)
      for (int j = 0; j < 5; j++) mem[a][6 * j +: 6] = 6'((a + 7 * j) % 64);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stop", int'(bus.stop), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_bad", int'(bus.bad_unit), 0);
    chk("rst_request", int'(bus.request), 0);
    chk("rst_addr", int'(bus.addressout), 0);
    chk("rst_tx", int'(bus.tx), 1);

    // Terminal block of code-1 words.
    for (int a = 100; a < 114; a++) mem[a] = {5{6'd1}};
    rx_log.delete();
    issue(19, 100, 1'b1);
    chk("t1_stop", int'(bus.stop), 1);
    chk("t1_request", int'(bus.request), 1);
    chk("t1_addr", int'(bus.addressout), 100);
    chk("t1_busy", int'(bus.busy), 1);
    wait_done(5000);
    chk("t1_idle", int'(bus.busy), 0);
    n_a = 0;
    foreach (rx_log[i]) if (rx_log[i] == 65) n_a++;
    chk("t1_a_count", n_a, 70);
    chk("t1_char_count", rx_log.size(), 70 + EolLen);
    chk("t1_last", rx_log[rx_log.size() - 1], 10);

    // Printer command queued behind the terminal.
    issue(19, 100, 1'b1);
    repeat (30) @(negedge clk);
    issue(18, 0, 1'b1);
    chk("t2_stop", int'(bus.stop), 1);
    chk("t2_pending", int'(bus.pending), 1);
    wait_done(15000);
    chk("t2_pending_end", int'(bus.pending), 0);

    // Fill the queue, stall one command, ignore a start while stalled.
    issue(19, 100, 1'b1);
    @(negedge clk);
    issue(17, 200, 1'b1);
    chk("t3_pend1", int'(bus.pending), 1);
    @(negedge clk);
    issue(18, 300, 1'b1);
    chk("t3_stop2", int'(bus.stop), 1);
    chk("t3_pend2", int'(bus.pending), 2);
    @(negedge clk);
    issue(17, 400, 1'b1);
    chk("t3_stall_nostop", int'(bus.stop), 0);
    chk("t3_stall_pend", int'(bus.pending), 2);
    @(negedge clk);
    issue(18, 900, 1'b0);
    chk("t3_ignored", int'(bus.stop), 0);
    found = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      @(negedge clk);
      if (bus.stop) found = 1;
    end
    chk("t3_late_stop", found, 1);
    chk("t3_pend_after", int'(bus.pending), 2);
    chk("t3_req_after", int'(bus.request), 1);
    wait_done(30000);

    // Invalid unit.
    issue(5, 0, 1'b0);
    chk("t4_bad", int'(bus.bad_unit), 1);
    chk("t4_stop", int'(bus.stop), 1);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_pending", int'(bus.pending), 0);
    chk("t4_tx", int'(bus.tx), 1);
    @(negedge clk);
    chk("t4_bad_off", int'(bus.bad_unit), 0);

    // Reset mid-character, then an address wrap.
    issue(19, 0, 1'b1);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (bus.tx == 1'b0) found = 1;
    end
    chk("t5_tx_started", found, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_stop", int'(bus.stop), 0);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_pending", int'(bus.pending), 0);
    chk("t5_bad", int'(bus.bad_unit), 0);
    chk("t5_request", int'(bus.request), 0);
    chk("t5_addr", int'(bus.addressout), 0);
    chk("t5_tx", int'(bus.tx), 1);
    exp_addr.delete();
    exp_chr.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req_log.delete();
    issue(19, 4095, 1'b1);
    wait_done(5000);
    chk("t5_req_count", req_log.size(), 14);
    if (req_log.size() >= 2) begin
      chk("t5_first_addr", req_log[0], 4095);
      chk("t5_wrap_addr", req_log[1], 0);
    end

    // Translation spot check.
    mem[500] = {6'd30, 6'd40, 6'd0, 6'd55, 6'd20};
    rx_log.delete();
    issue(19, 500, 1'b1);
    wait_done(5000);
    chk("t6_count", rx_log.size(), 70 + EolLen);
    if (rx_log.size() >= 5) begin
      chk("t6_c0", rx_log[0], 8'h30);
      chk("t6_c1", rx_log[1], 8'h2e);
      chk("t6_c2", rx_log[2], 8'h20);
      chk("t6_c3", rx_log[3], 8'h27);
      chk("t6_c4", rx_log[4], 8'h3f);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
